// File: rtl/agu_arbiter.sv
// agu_arbiter: round-robin share of one AGU across issue ports, base+offset into a 2-entry result queue.
// Optional AGU_ARB_MISALIGN_EN adds req_size_i and a per-entry out_misaligned_o flag.
module agu_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  localparam int SRC_W  = $clog2(NUM_REQ),
  localparam int IW     = SRC_W + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*XLEN-1:0]  req_base_i,
  input  logic [NUM_REQ*XLEN-1:0]  req_offset_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
`ifdef AGU_ARB_MISALIGN_EN
  input  logic [NUM_REQ*2-1:0]     req_size_i,
  output logic                     out_misaligned_o,
`endif
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_addr_o,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic [SRC_W-1:0]         out_src_o
);
  logic [SRC_W-1:0] rr_q, rr_d, win;
  logic [1:0]       cnt_q, cnt_d;
  logic             head_q, wr, pop, space, found, grant;
  logic [IW-1:0]    idx;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  addr_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic [SRC_W-1:0] src_q  [2];
  assign pop   = out_valid_o & out_ready_i;
  assign space = (cnt_q != 2'd2) | pop;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + IW'(k);
      idx = idx >= IW'(NUM_REQ) ? idx - IW'(NUM_REQ) : idx;
      if (!found && req_valid_i[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SRC_W-1:0];
      end
    end
  end
  assign grant       = found & space & ~squash_i & ~reset;
  assign req_ready_o = grant ? NUM_REQ'(1) << win : '0;
  assign sum         = req_base_i[int'(win)*XLEN +: XLEN] + req_offset_i[int'(win)*XLEN +: XLEN];
  // Tail slot; with a full queue and a pop it lands on the slot being vacated.
  assign wr          = head_q ^ cnt_q[0];
  assign rr_d        = win == SRC_W'(NUM_REQ-1) ? '0 : win + 1'b1;
  assign cnt_d       = squash_i ? 2'd0 : cnt_q + {1'b0, grant} - {1'b0, pop};
  assign out_valid_o = cnt_q != 2'd0;
  assign out_addr_o  = out_valid_o ? addr_q[head_q] : '0;
  assign out_tag_o   = out_valid_o ? tag_q[head_q]  : '0;
  assign out_src_o   = out_valid_o ? src_q[head_q]  : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      rr_q   <= '0;
      head_q <= 1'b0;
      addr_q <= '{default: '0};
      tag_q  <= '{default: '0};
      src_q  <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      if (pop) head_q <= ~head_q;
      if (grant) begin
        rr_q       <= rr_d;
        addr_q[wr] <= sum;
        tag_q[wr]  <= req_tag_i[int'(win)*TAG_W +: TAG_W];
        src_q[wr]  <= win;
      end
    end
  end
`ifdef AGU_ARB_MISALIGN_EN
  logic [1:0] size;
  logic       mis;
  logic       mis_q [2];
  assign size             = req_size_i[int'(win)*2 +: 2];
  assign mis              = (size == 2'd1 & sum[0]) | (size == 2'd2 & |sum[1:0]);
  assign out_misaligned_o = out_valid_o ? mis_q[head_q] : 1'b0;
  always_ff @(posedge clock) begin
    if (reset) mis_q <= '{default: 1'b0};
    else if (grant) mis_q[wr] <= mis;
  end
`endif
endmodule

// File: tb/tb_agu_arbiter.sv
// tb_agu_arbiter: randomized + directed scoreboard bench for agu_arbiter against a queue-based reference model.
module tb_agu_arbiter;
  localparam int N = 3, XLEN = 32, TAG_W = 6, SW = 2;
  logic clock = 1'b0, reset = 1'b1, squash = 1'b0, out_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*XLEN-1:0] req_base = '0, req_offset = '0;
  logic [N*TAG_W-1:0] req_tag = '0;
  logic [2*N-1:0] req_size = '0;
  logic out_valid, out_mis;
  logic [XLEN-1:0] out_addr;
  logic [TAG_W-1:0] out_tag;
  logic [SW-1:0] out_src;
  typedef struct {
    logic [XLEN-1:0]  addr;
    logic [TAG_W-1:0] tag;
    int               src;
    logic             mis;
  } ent_t;
  ent_t sb[$];
  ent_t me;
  int rr = 0;
  int vectors = 0, miscompares = 0;

  agu_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .squash_i(squash),
    .req_valid_i(req_valid), .req_base_i(req_base), .req_offset_i(req_offset), .req_tag_i(req_tag),
`ifdef AGU_ARB_MISALIGN_EN
    .req_size_i(req_size), .out_misaligned_o(out_mis),
`endif
    .req_ready_o(req_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_tag_o(out_tag), .out_src_o(out_src)
  );
`ifndef AGU_ARB_MISALIGN_EN
  assign out_mis = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(int i, logic [XLEN-1:0] b, logic [XLEN-1:0] o, logic [TAG_W-1:0] t, logic [1:0] sz);
    req_base[i*XLEN +: XLEN]    = b;
    req_offset[i*XLEN +: XLEN]  = o;
    req_tag[i*TAG_W +: TAG_W]   = t;
    req_size[i*2 +: 2]          = sz;
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // One cycle: inputs were driven at the negedge; predict the grant, then fold it into the model after the edge.
  task automatic step(output int g);
    bit space;
    ent_t e;
    logic [1:0] sz;
    #1;
    space = sb.size() < 2 || (sb.size() != 0 && out_ready);
    g = (reset || squash || !space) ? -1 : model_winner();
    chk("req_ready", {61'd0, req_ready}, g < 0 ? 64'd0 : 64'd1 << g);
    @(posedge clock);
    #1;
    if (reset) begin
      sb.delete();
      rr = 0;
      chk("rst_valid", {63'd0, out_valid}, 0);
      chk("rst_addr", {32'd0, out_addr}, 0);
      chk("rst_tag", {58'd0, out_tag}, 0);
      chk("rst_src", {62'd0, out_src}, 0);
    end else begin
      if (squash) sb.delete();
      if (g >= 0) begin
        e.addr = req_base[g*XLEN +: XLEN] + req_offset[g*XLEN +: XLEN];
        e.tag  = req_tag[g*TAG_W +: TAG_W];
        e.src  = g;
        sz     = req_size[g*2 +: 2];
`ifdef AGU_ARB_MISALIGN_EN
        e.mis  = (sz == 2'd1 && e.addr[0]) || (sz == 2'd2 && e.addr[1:0] != 2'd0);
`else
        e.mis  = 1'b0;
`endif
        sb.push_back(e);
        rr = (g + 1) % N;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        if (sb.size() == 0) chk("idle_addr", {32'd0, out_addr}, 0);
        else if (out_ready) begin
          me = sb.pop_front();
          chk("out_addr", {32'd0, out_addr}, {32'd0, me.addr});
          chk("out_tag", {58'd0, out_tag}, {58'd0, me.tag});
          chk("out_src", {62'd0, out_src}, 64'(me.src));
          chk("out_mis", {63'd0, out_mis}, {63'd0, me.mis});
        end
      end
    end
  end

  task automatic rand_req(int i);
    logic [XLEN-1:0] b, o;
    b = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
    o = ($urandom % 2 == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
    set_req(i, b, o, TAG_W'($urandom), 2'($urandom_range(0, 2)));
    req_valid[i] = $urandom % 3 != 0;
  endtask

  task automatic rand_cycles(int n);
    int g;
    for (int c = 0; c < n; c++) begin
      out_ready = $urandom % 4 != 0;
      squash    = $urandom % 20 == 0;
      step(g);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || g == i) rand_req(i);
    end
  endtask

  initial begin
    int g, n;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * i, 32'h4, TAG_W'(i + 1), 2'd0);
    @(negedge clock);
    step(g);
    step(g);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(g);
      chk("rr_seq", 64'(g), 64'(c % N));
      set_req(c % N, $urandom, $urandom, TAG_W'($urandom), 2'd0);
    end
    req_valid = '0;
    step(g);
    step(g);
    set_req(0, 32'h0000_1000, 32'hFFFF_FFFC, 6'h11, 2'd0);
    req_valid = 3'b001;
    step(g);
    chk("arith_neg", {32'd0, out_addr}, 64'h0000_0FFC);
    set_req(2, 32'hFFFF_FFFF, 32'h1, 6'h22, 2'd0);
    req_valid = 3'b100;
    step(g);
    chk("arith_wrap", {32'd0, out_addr}, 64'h0);
    req_valid = '0;
    step(g);
    step(g);
    out_ready = 1'b0;
    req_valid = 3'b010;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step(g);
      if (g >= 0) n++;
      set_req(1, $urandom, $urandom, TAG_W'($urandom), 2'd0);
    end
    chk("bp_grants", 64'(n), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(g);
      chk("bp_regrant", 64'(g), 64'd1);
    end
    req_valid = '0;
    step(g);
    step(g);
    out_ready = 1'b0;
    req_valid = 3'b010;
    step(g);
    step(g);
    req_valid = 3'b001;
    squash    = 1'b1;
    step(g);
    chk("sq_grant", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sq_valid", {63'd0, out_valid}, 0);
    squash = 1'b0;
    step(g);
    chk("sq_next", 64'(g), 64'd0);
    req_valid = '0;
    out_ready = 1'b1;
    step(g);
    step(g);
`ifdef AGU_ARB_MISALIGN_EN
    set_req(0, 32'h1000, 32'h2, 6'h01, 2'd2);
    req_valid = 3'b001;
    step(g);
    chk("mis_word", {63'd0, out_mis}, 1);
    set_req(1, 32'h1000, 32'h2, 6'h02, 2'd1);
    req_valid = 3'b010;
    step(g);
    chk("mis_half", {63'd0, out_mis}, 0);
    req_valid = '0;
    step(g);
`endif
    rand_cycles(400);
    squash = 1'b0;
    reset  = 1'b1;
    step(g);
    reset = 1'b0;
    rand_cycles(100);
    squash    = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    step(g);
    step(g);
    step(g);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
